// File: rtl/ic_bd_transpose_buffer_if.sv
// Row-in / column-out stream bundle between the row and column BinDCT passes.
// The master drives rows and receives columns; the slave is the transpose buffer.
interface ic_bd_transpose_buffer_if #(
    parameter int DW = 12
);
    logic              in_valid;
    logic [8*DW-1:0]   in_row;
    logic              out_valid;
    logic [8*DW-1:0]   out_col;
    logic [2:0]        out_idx;
    logic              out_last;

    modport master (
        output in_valid, in_row,
        input  out_valid, out_col, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_row,
        output out_valid, out_col, out_idx, out_last
    );
endinterface

// File: rtl/ic_bd_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows of a block are written into one bank
// while the previously completed bank is streamed out column by column.
module ic_bd_transpose_buffer #(
    parameter int DW = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    ic_bd_transpose_buffer_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } rd_state_t;

    // Bank contents are plain storage with no reset.
    logic [DW-1:0]   mem [2][8][8];

    rd_state_t       state, state_nxt;
    logic            wr_bank, wr_bank_nxt;
    logic [2:0]      wr_row, wr_row_nxt;
    logic            rd_bank, rd_bank_nxt;
    logic [2:0]      rd_col, rd_col_nxt;
    logic [1:0]      full, full_nxt;
    logic            rd_fire;
    logic [8*DW-1:0] rd_word;

    logic            out_valid_q, out_valid_nxt;
    logic [8*DW-1:0] out_col_q, out_col_nxt;
    logic [2:0]      out_idx_q, out_idx_nxt;
    logic            out_last_q, out_last_nxt;

    logic            wr_en;

    // A row presented during reset is discarded.
    assign wr_en = bus.in_valid & ~reset;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int e = 0; e < 8; e++) begin
                mem[wr_bank][wr_row][e] <= bus.in_row[(7-e)*DW +: DW];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < 8; r++) begin
            rd_word[(7-r)*DW +: DW] = mem[rd_bank][r][rd_col];
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_bank_nxt   = wr_bank;
        wr_row_nxt    = wr_row;
        rd_bank_nxt   = rd_bank;
        rd_col_nxt    = rd_col;
        full_nxt      = full;
        rd_fire       = 1'b0;
        out_valid_nxt = 1'b0;
        out_col_nxt   = out_col_q;
        out_idx_nxt   = out_idx_q;
        out_last_nxt  = out_last_q;

        if (bus.in_valid) begin
            wr_row_nxt = wr_row + 3'd1;
            if (wr_row == 3'd7) begin
                full_nxt[wr_bank] = 1'b1;
                wr_bank_nxt       = ~wr_bank;
            end
        end

        // Column 0 is emitted on the same edge that leaves IDLE, so the first
        // column follows the last row by exactly one edge.
        case (state)
            S_IDLE:  rd_fire = full[rd_bank];
            S_READ:  rd_fire = 1'b1;
            default: rd_fire = 1'b0;
        endcase

        if (rd_fire) begin
            out_valid_nxt = 1'b1;
            out_col_nxt   = rd_word;
            out_idx_nxt   = rd_col;
            out_last_nxt  = (rd_col == 3'd7);
            rd_col_nxt    = rd_col + 3'd1;
            state_nxt     = S_READ;
            if (rd_col == 3'd7) begin
                full_nxt[rd_bank] = 1'b0;
                rd_bank_nxt       = ~rd_bank;
                state_nxt         = full[~rd_bank] ? S_READ : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_bank     <= 1'b0;
            wr_row      <= 3'd0;
            rd_bank     <= 1'b0;
            rd_col      <= 3'd0;
            full        <= 2'b00;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_bank     <= wr_bank_nxt;
            wr_row      <= wr_row_nxt;
            rd_bank     <= rd_bank_nxt;
            rd_col      <= rd_col_nxt;
            full        <= full_nxt;
            out_valid_q <= out_valid_nxt;
            out_col_q   <= out_col_nxt;
            out_idx_q   <= out_idx_nxt;
            out_last_q  <= out_last_nxt;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

    // The reader always drains a bank in 8 cycles, so a row never targets a full bank.
    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        !(bus.in_valid && full[wr_bank]));

endmodule

// File: tb/tb_ic_bd_transpose_buffer.sv
// Directed bench for ic_bd_transpose_buffer: rows in, columns checked against
// hand-built blocks, with latency, continuity and reset scenarios.
module tb_ic_bd_transpose_buffer;

    localparam int DW = 12;
    localparam int W  = 8*DW;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ic_bd_transpose_buffer_if #(.DW(DW)) bus ();

    ic_bd_transpose_buffer #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] cap_col  [$];
    logic [2:0]   cap_idx  [$];
    logic         cap_last [$];
    int           cap_cyc  [$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            cap_col.push_back(bus.out_col);
            cap_idx.push_back(bus.out_idx);
            cap_last.push_back(bus.out_last);
            cap_cyc.push_back(cyc);
        end
    end

    function automatic logic [W-1:0] mk_row(input int base, input int r);
        logic [W-1:0] row;
        int v;
        row = '0;
        for (int c = 0; c < 8; c++) begin
            v = base + 8*r + c;
            row[(7-c)*DW +: DW] = v[DW-1:0];
        end
        return row;
    endfunction

    function automatic logic [W-1:0] mk_col(input int base, input int c);
        logic [W-1:0] col;
        int v;
        col = '0;
        for (int r = 0; r < 8; r++) begin
            v = base + 8*r + c;
            col[(7-r)*DW +: DW] = v[DW-1:0];
        end
        return col;
    endfunction

    task automatic clear_cap();
        cap_col.delete();
        cap_idx.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    task automatic send_row(input logic v, input logic [W-1:0] row);
        bus.in_valid = v;
        bus.in_row   = row;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_row(1'b0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_col !== '0) begin
            errors++; $display("FAIL reset_col: got %h want 0", bus.out_col);
        end
        checks++;
        if (bus.out_idx !== 3'd0) begin
            errors++; $display("FAIL reset_idx: got %0d want 0", bus.out_idx);
        end
        checks++;
        if (bus.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_last: got %b want 0", bus.out_last);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        int k;
        clear_cap();
        for (int r = 0; r < 8; r++) send_row(1'b1, mk_row(0, r));
        k = cyc;
        idle(12);
        checks++;
        if (cap_col.size() != 8) begin
            errors++; $display("FAIL single_count: got %0d want 8", cap_col.size());
        end
        for (int c = 0; c < 8 && c < cap_col.size(); c++) begin
            checks++;
            if (cap_col[c] !== mk_col(0, c)) begin
                errors++; $display("FAIL single_col%0d: got %h want %h", c, cap_col[c], mk_col(0, c));
            end
            checks++;
            if (cap_idx[c] !== c[2:0] || cap_last[c] !== (c == 7) || cap_cyc[c] != k + 1 + c) begin
                errors++;
                $display("FAIL single_tag%0d: got idx=%0d last=%b cyc=%0d want idx=%0d last=%b cyc=%0d",
                         c, cap_idx[c], cap_last[c], cap_cyc[c], c, (c == 7), k + 1 + c);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k0;
        int b;
        int c;
        k0 = 0;
        clear_cap();
        for (int i = 0; i < 24; i++) begin
            send_row(1'b1, mk_row(64*(i/8), i%8));
            if (i == 7) k0 = cyc;
        end
        idle(12);
        checks++;
        if (cap_col.size() != 24) begin
            errors++; $display("FAIL b2b_count: got %0d want 24", cap_col.size());
        end
        for (int i = 0; i < 24 && i < cap_col.size(); i++) begin
            b = i / 8;
            c = i % 8;
            checks++;
            if (cap_col[i] !== mk_col(64*b, c)) begin
                errors++; $display("FAIL b2b_col%0d: got %h want %h", i, cap_col[i], mk_col(64*b, c));
            end
            checks++;
            if (cap_idx[i] !== c[2:0] || cap_last[i] !== (c == 7) || cap_cyc[i] != k0 + 1 + i) begin
                errors++;
                $display("FAIL b2b_tag%0d: got idx=%0d last=%b cyc=%0d want idx=%0d last=%b cyc=%0d",
                         i, cap_idx[i], cap_last[i], cap_cyc[i], c, (c == 7), k0 + 1 + i);
            end
        end
    endtask

    task automatic test_sparse();
        int k;
        clear_cap();
        send_row(1'b1, mk_row(300, 0));
        for (int r = 1; r < 8; r++) begin
            idle(1);
            if (r == 7) begin
                checks++;
                if (cap_col.size() != 0) begin
                    errors++; $display("FAIL sparse_early: got %0d outputs want 0", cap_col.size());
                end
            end
            send_row(1'b1, mk_row(300, r));
        end
        k = cyc;
        idle(12);
        checks++;
        if (cap_col.size() != 8) begin
            errors++; $display("FAIL sparse_count: got %0d want 8", cap_col.size());
        end
        for (int c = 0; c < 8 && c < cap_col.size(); c++) begin
            checks++;
            if (cap_col[c] !== mk_col(300, c)) begin
                errors++; $display("FAIL sparse_col%0d: got %h want %h", c, cap_col[c], mk_col(300, c));
            end
            checks++;
            if (cap_idx[c] !== c[2:0] || cap_last[c] !== (c == 7) || cap_cyc[c] != k + 1 + c) begin
                errors++;
                $display("FAIL sparse_tag%0d: got idx=%0d last=%b cyc=%0d want idx=%0d last=%b cyc=%0d",
                         c, cap_idx[c], cap_last[c], cap_cyc[c], c, (c == 7), k + 1 + c);
            end
        end
    endtask

    task automatic test_negative();
        logic [W-1:0] row;
        logic [W-1:0] exp;
        clear_cap();
        for (int r = 0; r < 8; r++) begin
            row = {8{12'hFFF}};
            if (r == 3) row[(7-5)*DW +: DW] = 12'h800;
            send_row(1'b1, row);
        end
        idle(12);
        checks++;
        if (cap_col.size() != 8) begin
            errors++; $display("FAIL neg_count: got %0d want 8", cap_col.size());
        end
        for (int c = 0; c < 8 && c < cap_col.size(); c++) begin
            exp = {8{12'hFFF}};
            if (c == 5) exp[(7-3)*DW +: DW] = 12'h800;
            checks++;
            if (cap_col[c] !== exp) begin
                errors++; $display("FAIL neg_col%0d: got %h want %h", c, cap_col[c], exp);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        clear_cap();
        for (int r = 0; r < 5; r++) send_row(1'b1, mk_row(500, r));
        reset = 1'b1;
        send_row(1'b1, mk_row(900, 0));
        reset = 1'b0;
        for (int r = 0; r < 8; r++) send_row(1'b1, mk_row(1000, r));
        k = cyc;
        idle(12);
        checks++;
        if (cap_col.size() != 8) begin
            errors++; $display("FAIL rstwr_count: got %0d want 8", cap_col.size());
        end
        for (int c = 0; c < 8 && c < cap_col.size(); c++) begin
            checks++;
            if (cap_col[c] !== mk_col(1000, c)) begin
                errors++; $display("FAIL rstwr_col%0d: got %h want %h", c, cap_col[c], mk_col(1000, c));
            end
            checks++;
            if (cap_idx[c] !== c[2:0] || cap_last[c] !== (c == 7) || cap_cyc[c] != k + 1 + c) begin
                errors++;
                $display("FAIL rstwr_tag%0d: got idx=%0d last=%b cyc=%0d want idx=%0d last=%b cyc=%0d",
                         c, cap_idx[c], cap_last[c], cap_cyc[c], c, (c == 7), k + 1 + c);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int k;
        for (int r = 0; r < 8; r++) send_row(1'b1, mk_row(1500, r));
        idle(4);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd3) begin
            errors++; $display("FAIL rstrd_col3: got valid=%b idx=%0d want valid=1 idx=3", bus.out_valid, bus.out_idx);
        end
        reset = 1'b1;
        send_row(1'b0, '0);
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== 3'd0) begin
            errors++; $display("FAIL rstrd_abort: got valid=%b idx=%0d want valid=0 idx=0", bus.out_valid, bus.out_idx);
        end
        clear_cap();
        idle(10);
        checks++;
        if (cap_col.size() != 0) begin
            errors++; $display("FAIL rstrd_quiet: got %0d outputs want 0", cap_col.size());
        end
        for (int r = 0; r < 8; r++) send_row(1'b1, mk_row(2000, r));
        k = cyc;
        idle(12);
        checks++;
        if (cap_col.size() != 8) begin
            errors++; $display("FAIL rstrd_count: got %0d want 8", cap_col.size());
        end
        for (int c = 0; c < 8 && c < cap_col.size(); c++) begin
            checks++;
            if (cap_col[c] !== mk_col(2000, c)) begin
                errors++; $display("FAIL rstrd_col%0d: got %h want %h", c, cap_col[c], mk_col(2000, c));
            end
            checks++;
            if (cap_idx[c] !== c[2:0] || cap_last[c] !== (c == 7) || cap_cyc[c] != k + 1 + c) begin
                errors++;
                $display("FAIL rstrd_tag%0d: got idx=%0d last=%b cyc=%0d want idx=%0d last=%b cyc=%0d",
                         c, cap_idx[c], cap_last[c], cap_cyc[c], c, (c == 7), k + 1 + c);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_sparse();
        test_negative();
        test_reset_mid_write();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
